// File: rtl/rv151_csr.sv
// rv151 CSR file: 64-bit cycle/instret counters, mscratch, mhartid and a tohost mailbox.
// Define RV151_CSR_CNTWR_EN to map the writable machine counters at B00/B80/B02/B82.
module rv151_csr #(
  parameter logic [31:0] HART_ID    = 32'h0,
  parameter logic [11:0] TOHOST_ADR = 12'h51E,
  parameter logic [31:0] TOHOST_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cs_en,
  input  logic [11:0] cs_ad,
  input  logic        cs_we,
  input  logic [31:0] cs_wd,
  output logic [31:0] cs_rd,
  input  logic        ds_irc,
  input  logic        ds_hlt,
  input  logic        sc_rsr,
  output logic [31:0] th_dat,
  output logic        th_vld
);

  logic [63:0] cycle_r;
  logic [63:0] instret_r;
  logic [31:0] mscratch_r;
  logic [31:0] tohost_r;
  logic        th_vld_r;

  logic        wr_s;
  logic        th_wr_s;
  logic        ms_wr_s;
  logic [63:0] cyc_inc_s;
  logic [63:0] ins_inc_s;
  logic [63:0] cyc_nxt_s;
  logic [63:0] ins_nxt_s;
  logic [31:0] rd_s;

  assign wr_s    = cs_en & cs_we;
  assign th_wr_s = wr_s & (cs_ad == TOHOST_ADR);
  assign ms_wr_s = wr_s & (cs_ad == 12'h340);

  // Counter next values: a written half takes cs_wd, the other half keeps the incremented value.
  always_comb begin
    cyc_inc_s = cycle_r + {63'd0, ~ds_hlt};
    ins_inc_s = instret_r + {63'd0, ds_irc};
    cyc_nxt_s = cyc_inc_s;
    ins_nxt_s = ins_inc_s;
`ifdef RV151_CSR_CNTWR_EN
    if (wr_s) begin
      case (cs_ad)
        12'hB00: cyc_nxt_s[31:0]  = cs_wd;
        12'hB80: cyc_nxt_s[63:32] = cs_wd;
        12'hB02: ins_nxt_s[31:0]  = cs_wd;
        12'hB82: ins_nxt_s[63:32] = cs_wd;
        default: begin
          cyc_nxt_s = cyc_inc_s;
          ins_nxt_s = ins_inc_s;
        end
      endcase
    end else begin
      cyc_nxt_s = cyc_inc_s;
      ins_nxt_s = ins_inc_s;
    end
`endif
  end

  // Combinational read mux; counters return their pre-edge value.
  always_comb begin
    rd_s = 32'h0;
    if (!cs_en) begin
      rd_s = 32'h0;
    end else if (cs_ad == TOHOST_ADR) begin
      rd_s = tohost_r;
    end else begin
      case (cs_ad)
        12'hC00, 12'hC01: rd_s = cycle_r[31:0];
        12'hC80, 12'hC81: rd_s = cycle_r[63:32];
        12'hC02:          rd_s = instret_r[31:0];
        12'hC82:          rd_s = instret_r[63:32];
`ifdef RV151_CSR_CNTWR_EN
        12'hB00:          rd_s = cycle_r[31:0];
        12'hB80:          rd_s = cycle_r[63:32];
        12'hB02:          rd_s = instret_r[31:0];
        12'hB82:          rd_s = instret_r[63:32];
`endif
        12'h340:          rd_s = mscratch_r;
        12'hF14:          rd_s = HART_ID;
        default:          rd_s = 32'h0;
      endcase
    end
  end

  assign cs_rd = rd_s;

  // State registers; soft reset overrides every write and increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_r    <= 64'h0;
      instret_r  <= 64'h0;
      mscratch_r <= 32'h0;
      tohost_r   <= TOHOST_RST;
      th_vld_r   <= 1'b0;
    end else if (sc_rsr) begin
      cycle_r    <= 64'h0;
      instret_r  <= 64'h0;
      mscratch_r <= 32'h0;
      tohost_r   <= TOHOST_RST;
      th_vld_r   <= 1'b0;
    end else begin
      cycle_r   <= cyc_nxt_s;
      instret_r <= ins_nxt_s;
      th_vld_r  <= th_wr_s;
      if (ms_wr_s) begin
        mscratch_r <= cs_wd;
      end
      if (th_wr_s) begin
        tohost_r <= cs_wd;
      end
    end
  end

  assign th_dat = tohost_r;
  assign th_vld = th_vld_r;

endmodule

// File: tb/tb_rv151_csr.sv
// Directed self-checking bench for rv151_csr; inputs change on the falling edge.
`timescale 1ns/1ps
module tb_rv151_csr;

  logic        clk;
  logic        rstn;
  logic        cs_en;
  logic [11:0] cs_ad;
  logic        cs_we;
  logic [31:0] cs_wd;
  logic [31:0] cs_rd;
  logic        ds_irc;
  logic        ds_hlt;
  logic        sc_rsr;
  logic [31:0] th_dat;
  logic        th_vld;

  int n_run;
  int n_fail;

  rv151_csr dut (
    .clk    (clk),
    .rstn   (rstn),
    .cs_en  (cs_en),
    .cs_ad  (cs_ad),
    .cs_we  (cs_we),
    .cs_wd  (cs_wd),
    .cs_rd  (cs_rd),
    .ds_irc (ds_irc),
    .ds_hlt (ds_hlt),
    .sc_rsr (sc_rsr),
    .th_dat (th_dat),
    .th_vld (th_vld)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got=%08h exp=%08h", tag, obs, exp_v);
    end
  endtask

  // Combinational read inside the low clock phase; does not advance time past an edge.
  task automatic rd(input string tag, input logic [11:0] ad, input logic [31:0] exp_v);
    cs_en = 1'b1;
    cs_we = 1'b0;
    cs_ad = ad;
    #1;
    chk(tag, cs_rd, exp_v);
    cs_en = 1'b0;
  endtask

  // One-cycle write: drive now, commit at the next rising edge, release at the falling edge.
  task automatic wr(input logic [11:0] ad, input logic [31:0] wd);
    cs_en = 1'b1;
    cs_we = 1'b1;
    cs_ad = ad;
    cs_wd = wd;
    @(negedge clk);
    cs_en = 1'b0;
    cs_we = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    cs_en  = 1'b0;
    cs_ad  = 12'h0;
    cs_we  = 1'b0;
    cs_wd  = 32'h0;
    ds_irc = 1'b0;
    ds_hlt = 1'b0;
    sc_rsr = 1'b0;

    // 1: reset, then 10 running cycles
    repeat (3) @(negedge clk);
    chk("rst_th_vld", {31'd0, th_vld}, 32'h0);
    chk("rst_th_dat", th_dat, 32'h0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    rd("t1_c00", 12'hC00, 32'd10);
    rd("t1_c80", 12'hC80, 32'd0);
    rd("t1_c02", 12'hC02, 32'd0);
    chk("t1_th_vld", {31'd0, th_vld}, 32'h0);

    // 2: 5 retire pulses, halted for 3 of them
    ds_irc = 1'b1;
    ds_hlt = 1'b1;
    repeat (3) @(negedge clk);
    ds_hlt = 1'b0;
    repeat (2) @(negedge clk);
    ds_irc = 1'b0;
    rd("t2_c02", 12'hC02, 32'd5);
    rd("t2_c00", 12'hC00, 32'd12);

    // 3: mscratch write, read-only counter write dropped
    wr(12'h340, 32'hDEADBEEF);
    rd("t3_ms", 12'h340, 32'hDEADBEEF);
    cs_ad = 12'h340;
    #1;
    chk("t3_rd_dis", cs_rd, 32'h0);
    wr(12'hC00, 32'h0);
    rd("t3_c00_ro", 12'hC00, 32'd14);

    // 4: tohost single and back-to-back writes
    wr(12'h51E, 32'h1);
    chk("t4_dat", th_dat, 32'h1);
    chk("t4_vld", {31'd0, th_vld}, 32'h1);
    @(negedge clk);
    chk("t4_vld_off", {31'd0, th_vld}, 32'h0);
    chk("t4_dat_hold", th_dat, 32'h1);
    cs_en = 1'b1;
    cs_we = 1'b1;
    cs_ad = 12'h51E;
    cs_wd = 32'h2;
    @(negedge clk);
    cs_wd = 32'h3;
    chk("t4_b2b_dat0", th_dat, 32'h2);
    chk("t4_b2b_vld0", {31'd0, th_vld}, 32'h1);
    @(negedge clk);
    cs_en = 1'b0;
    cs_we = 1'b0;
    chk("t4_b2b_dat1", th_dat, 32'h3);
    chk("t4_b2b_vld1", {31'd0, th_vld}, 32'h1);
    @(negedge clk);
    chk("t4_b2b_off", {31'd0, th_vld}, 32'h0);
    rd("t4_rd_th", 12'h51E, 32'h3);
    rd("t4_c01", 12'hC01, 32'd19);
    rd("t4_c81", 12'hC81, 32'd0);
    rd("t4_c82", 12'hC82, 32'd0);
    rd("t4_f14", 12'hF14, 32'h0);
    rd("t4_unmap", 12'h123, 32'h0);

    // 5: writable machine counters
`ifdef RV151_CSR_CNTWR_EN
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFF);
    rd("t5_b00", 12'hB00, 32'hFFFF_FFFF);
    rd("t5_c80_pre", 12'hC80, 32'h0);
    @(negedge clk);
    rd("t5_c00_wrap", 12'hC00, 32'h0);
    rd("t5_c80_carry", 12'hC80, 32'h1);
    rd("t5_b80", 12'hB80, 32'h1);
    ds_irc = 1'b1;
    wr(12'hB02, 32'h7);
    ds_irc = 1'b0;
    rd("t5_b02", 12'hB02, 32'h7);
    rd("t5_c02", 12'hC02, 32'h7);
    rd("t5_b82", 12'hB82, 32'h0);
`else
    rd("t5_b00_unmap", 12'hB00, 32'h0);
    wr(12'hB00, 32'h5);
    rd("t5_c00_nowr", 12'hC00, 32'd20);
    rd("t5_b02_unmap", 12'hB02, 32'h0);
    rd("t5_c02", 12'hC02, 32'd5);
`endif

    // 6: soft reset beats a simultaneous tohost write
    sc_rsr = 1'b1;
    cs_en  = 1'b1;
    cs_we  = 1'b1;
    cs_ad  = 12'h51E;
    cs_wd  = 32'hAA;
    @(negedge clk);
    sc_rsr = 1'b0;
    cs_en  = 1'b0;
    cs_we  = 1'b0;
    chk("t6_dat", th_dat, 32'h0);
    chk("t6_vld", {31'd0, th_vld}, 32'h0);
    rd("t6_c00", 12'hC00, 32'h0);
    rd("t6_c80", 12'hC80, 32'h0);
    rd("t6_c02", 12'hC02, 32'h0);
    rd("t6_ms", 12'h340, 32'h0);
    @(negedge clk);
    chk("t6_vld_next", {31'd0, th_vld}, 32'h0);
    rd("t6_c00_run", 12'hC00, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
